// File: rtl/biu_constants_pkg.sv
// rtl/biu_constants_pkg.sv - bus interface unit access sizes and cache line commands
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

    // Whole-line commands issued to the BIU by the cache controller
    typedef enum logic [1:0] {
        NOP      = 2'd0,
        READWAY  = 2'd1,
        WRITEWAY = 2'd2
    } biucmd_t;

endpackage

// File: rtl/riscv_cache_pkg.sv
// rtl/riscv_cache_pkg.sv - data cache controller state type and byte-enable helper
package riscv_cache_pkg;
    import biu_constants_pkg::*;

    typedef enum logic [2:0] {
        ARMED,
        FLUSH,
        NONCACHEABLE,
        EVICT,
        FILL,
        RECOVER
    } state_t;

    // Byte enables of an access within one XLEN word. On a 32-bit core only
    // adr[1:0] selects the byte lane; adr[2] belongs to the word index.
    function automatic logic [7:0] size2be(input biu_size_t size,
                                           input logic [2:0]  adr,
                                           input logic        xlen64);
        logic [7:0] mask;
        logic [2:0] off;
        off = xlen64 ? adr : {1'b0, adr[1:0]};
        case (size)
            BYTE:    mask = 8'h01;
            HWORD:   mask = 8'h03;
            WORD:    mask = 8'h0f;
            default: mask = 8'hff;
        endcase
        return mask << off;
    endfunction

endpackage

// File: rtl/riscv_cache_nc_cnt.sv
// rtl/riscv_cache_nc_cnt.sv - outstanding non-cacheable transfer counter and drop flag
//
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   inc_i          a non-cacheable request was accepted this cycle
//   dec_i          a non-cacheable transfer completed (ack or error) this cycle
//   drop_set_i     pipe flushed: responses still in flight must be discarded
//   drop_clr_i     nothing left in flight and no new request: stop discarding
//   cnt_o          transfers in flight, saturating at 0 and DEPTH
//   drop_o         discard responses
module riscv_cache_nc_cnt #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             drop_set_i,
    input  logic             drop_clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             drop_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && !dec_i && (cnt_o < CNT_W'(DEPTH))) begin
            cnt_o <= cnt_o + 1'b1;
        end else if (dec_i && !inc_i && (cnt_o != '0)) begin
            cnt_o <= cnt_o - 1'b1;
        end
    end

    // Clear wins: a flush seen when nothing is in flight has nothing to drop
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_o <= 1'b0;
        end else if (drop_clr_i) begin
            drop_o <= 1'b0;
        end else if (drop_set_i) begin
            drop_o <= 1'b1;
        end
    end

endmodule

// File: rtl/riscv_dcache_hit.sv
// rtl/riscv_dcache_hit.sv - data cache hit/miss controller with non-cacheable path
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   flush_i                       pipeline flush
//   cacheflush_req_i              write back and invalidate the whole cache
//   dcflush_rdy_i / flushing_o    cache flush done / in progress
//   req_i, we_i, adr_i, size_i, d_i  pipeline access
//   cacheable_i, cache_hit_i, victim_dirty_i, cache_line_i  tag/data lookup results
//   stall_o, q_o, ack_o, err_o    pipeline response
//   biucmd_o, biucmd_ack_i        line eviction/fill command to the BIU
//   nc_req_o, biu_stb_ack_i, biu_ack_i, biu_err_i, biu_q_i  non-cacheable bus access
//   line_be_o                     store-hit byte enables into the line, zero = no write
module riscv_dcache_hit
    import biu_constants_pkg::*;
    import riscv_cache_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PLEN           = XLEN == 32 ? 34 : 56,
    parameter int BLOCK_SIZE     = XLEN,
    parameter int INFLIGHT_DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    cacheflush_req_i,
    input  logic                    dcflush_rdy_i,
    output logic                    flushing_o,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [PLEN-1:0]         adr_i,
    input  biu_size_t               size_i,
    input  logic [XLEN-1:0]         d_i,
    input  logic                    cacheable_i,
    input  logic                    cache_hit_i,
    input  logic                    victim_dirty_i,
    input  logic [BLOCK_SIZE-1:0]   cache_line_i,
    output logic                    stall_o,
    output logic [XLEN-1:0]         q_o,
    output logic                    ack_o,
    output logic                    err_o,
    output biucmd_t                 biucmd_o,
    input  logic                    biucmd_ack_i,
    output logic                    nc_req_o,
    input  logic                    biu_stb_ack_i,
    input  logic                    biu_ack_i,
    input  logic                    biu_err_i,
    input  logic [XLEN-1:0]         biu_q_i,
    output logic [BLOCK_SIZE/8-1:0] line_be_o
);

    localparam int XB        = XLEN / 8;
    localparam int XB_LOG    = $clog2(XB);
    localparam int BLK_BYTES = BLOCK_SIZE / 8;
    localparam int WORDS     = BLOCK_SIZE / XLEN;
    localparam int WIDX      = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int CNT_W     = $clog2(INFLIGHT_DEPTH + 1);

    state_t               state_q, state_d;
    biucmd_t              biucmd_q, biucmd_d;
    logic                 cf_latch_q;
    logic                 cf_pend;
    logic [CNT_W-1:0]     nc_cnt;
    logic                 nc_drop;

    logic [PLEN-1:0]      adr_sh;
    logic [WIDX-1:0]      word_idx;
    logic [XLEN-1:0]      hit_word;
    logic [7:0]           be8;
    logic [XB-1:0]        be_word;
    logic [BLK_BYTES-1:0] be_line;
    logic                 hit_ok;
    logic                 nc_ok;

    logic                 stall_c, ack_c, err_c, nc_req_c, flushing_c;
    logic [BLK_BYTES-1:0] line_be_c;
    logic [XLEN-1:0]      q_c;

    // Store data is replicated across the line by the data array itself;
    // only the byte enables are produced here.
    logic                 unused_bits;
    assign unused_bits = ^{d_i, adr_i, be8};

    // Word within the line addressed by the access (0 when the line is one word)
    assign adr_sh   = adr_i >> XB_LOG;
    assign word_idx = adr_sh[WIDX-1:0] & WIDX'(WORDS - 1);
    assign hit_word = XLEN'(cache_line_i >> (XLEN * word_idx));

    assign be8     = size2be(size_i, adr_i[2:0], XLEN == 64);
    assign be_word = be8[XB-1:0];
    assign be_line = BLK_BYTES'(be_word) << (XB * word_idx);

    // A cache flush request wins over everything in ARMED, so a hit arriving
    // together with it is not acknowledged and no new bus transfer starts.
    assign cf_pend = cacheflush_req_i | cf_latch_q;
    assign hit_ok  = req_i & cacheable_i & cache_hit_i & ~flush_i & ~cf_pend;
    assign nc_ok   = req_i & ~cacheable_i & ~flush_i & (nc_cnt < CNT_W'(INFLIGHT_DEPTH));

    always_comb begin
        state_d    = state_q;
        biucmd_d   = NOP;
        stall_c    = 1'b0;
        ack_c      = 1'b0;
        err_c      = 1'b0;
        nc_req_c   = 1'b0;
        flushing_c = 1'b0;
        line_be_c  = '0;
        q_c        = hit_word;

        case (state_q)
            ARMED: begin
                nc_req_c = nc_ok & ~cf_pend;
                stall_c  = req_i & (cacheable_i ? ~cache_hit_i : ~biu_stb_ack_i);
                if (hit_ok) begin
                    ack_c = 1'b1;
                    if (we_i) line_be_c = be_line;
                end
                if (cf_pend) begin
                    state_d = FLUSH;
                end else if (flush_i) begin
                    state_d = ARMED;
                end else if (req_i && !cacheable_i) begin
                    state_d = NONCACHEABLE;
                end else if (req_i && !cache_hit_i) begin
                    if (victim_dirty_i) begin
                        state_d  = EVICT;
                        biucmd_d = WRITEWAY;
                    end else begin
                        state_d  = FILL;
                        biucmd_d = READWAY;
                    end
                end
            end

            NONCACHEABLE: begin
                nc_req_c = nc_ok;
                ack_c    = biu_ack_i & ~nc_drop;
                err_c    = biu_err_i & ~nc_drop;
                q_c      = biu_q_i;
                stall_c  = (req_i & ~ack_c) | (nc_cnt != '0);
                if ((nc_cnt == '0) && !nc_ok) state_d = ARMED;
            end

            EVICT: begin
                stall_c = 1'b1;
                err_c   = biu_err_i;
                if (biu_err_i) begin
                    state_d = RECOVER;
                end else if (biucmd_ack_i) begin
                    state_d  = FILL;
                    biucmd_d = READWAY;
                end
            end

            FILL: begin
                stall_c = 1'b1;
                err_c   = biu_err_i;
                if (biu_err_i || biucmd_ack_i) state_d = RECOVER;
            end

            FLUSH: begin
                stall_c    = 1'b1;
                flushing_c = 1'b1;
                if (dcflush_rdy_i) state_d = RECOVER;
            end

            RECOVER: begin
                // Freshly filled line: a hit can complete while settling
                stall_c = ~(req_i & cache_hit_i);
                if (hit_ok) begin
                    ack_c = 1'b1;
                    if (we_i) line_be_c = be_line;
                end
                state_d = ARMED;
            end

            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ARMED;
            biucmd_q <= NOP;
        end else begin
            state_q  <= state_d;
            biucmd_q <= biucmd_d;
        end
    end

    // Remember a flush request that arrives while busy until FLUSH is entered
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cf_latch_q <= 1'b0;
        end else if ((state_q == ARMED) && cf_pend) begin
            cf_latch_q <= 1'b0;
        end else if (cacheflush_req_i && (state_q != FLUSH)) begin
            cf_latch_q <= 1'b1;
        end
    end

    riscv_cache_nc_cnt #(
        .DEPTH (INFLIGHT_DEPTH),
        .CNT_W (CNT_W)
    ) u_nc_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inc_i      (nc_req_o & biu_stb_ack_i),
        .dec_i      (biu_ack_i | biu_err_i),
        .drop_set_i ((state_q == NONCACHEABLE) & flush_i),
        .drop_clr_i ((state_q == NONCACHEABLE) & (nc_cnt == '0) & ~nc_req_c),
        .cnt_o      (nc_cnt),
        .drop_o     (nc_drop)
    );

    // Control outputs are held quiet while reset is asserted
    assign stall_o    = rst_ni & stall_c;
    assign ack_o      = rst_ni & ack_c;
    assign err_o      = rst_ni & err_c;
    assign nc_req_o   = rst_ni & nc_req_c;
    assign flushing_o = rst_ni & flushing_c;
    assign line_be_o  = rst_ni ? line_be_c : '0;
    assign q_o        = q_c;
    assign biucmd_o   = biucmd_q;

endmodule

// File: tb/tb_riscv_dcache_hit.sv
// tb/tb_riscv_dcache_hit.sv - self-checking bench for riscv_dcache_hit
module tb_riscv_dcache_hit;
    import biu_constants_pkg::*;
    import riscv_cache_pkg::*;

    localparam int XLEN  = 32;
    localparam int PLEN  = 34;
    localparam int BLK   = 128;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_ni, flush_i, cacheflush_req_i, dcflush_rdy_i;
    logic             req_i, we_i, cacheable_i, cache_hit_i, victim_dirty_i;
    logic [PLEN-1:0]  adr_i;
    biu_size_t        size_i;
    logic [XLEN-1:0]  d_i, biu_q_i, q_o;
    logic [BLK-1:0]   cache_line_i;
    logic             biucmd_ack_i, biu_stb_ack_i, biu_ack_i, biu_err_i;
    logic             flushing_o, stall_o, ack_o, err_o, nc_req_o;
    biucmd_t          biucmd_o;
    logic [BLK/8-1:0] line_be_o;

    riscv_dcache_hit #(
        .XLEN(XLEN), .PLEN(PLEN), .BLOCK_SIZE(BLK), .INFLIGHT_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .cacheflush_req_i(cacheflush_req_i), .dcflush_rdy_i(dcflush_rdy_i),
        .flushing_o(flushing_o), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
        .size_i(size_i), .d_i(d_i), .cacheable_i(cacheable_i),
        .cache_hit_i(cache_hit_i), .victim_dirty_i(victim_dirty_i),
        .cache_line_i(cache_line_i), .stall_o(stall_o), .q_o(q_o),
        .ack_o(ack_o), .err_o(err_o), .biucmd_o(biucmd_o),
        .biucmd_ack_i(biucmd_ack_i), .nc_req_o(nc_req_o),
        .biu_stb_ack_i(biu_stb_ack_i), .biu_ack_i(biu_ack_i),
        .biu_err_i(biu_err_i), .biu_q_i(biu_q_i), .line_be_o(line_be_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: controller mode, transfers in flight, drop and
    // pending-flush flags, and the command expected on biucmd_o this cycle.
    typedef struct packed {
        logic        stall, ack, err, nc, flushing;
        logic [15:0] be;
        logic [31:0] q;
    } exp_t;

    state_t  m_state = ARMED;
    int      m_cnt   = 0;
    bit      m_drop  = 1'b0;
    bit      m_cf    = 1'b0;
    biucmd_t m_cmd   = NOP;
    bit      started = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        int off, nb;
        bit pend, hit_ok;
        logic [15:0] be;
        e      = '0;
        off    = int'(adr_i % 16);
        nb     = (size_i == BYTE) ? 1 : (size_i == HWORD) ? 2 : (size_i == WORD) ? 4 : 8;
        be     = 16'(((1 << nb) - 1) << off);
        pend   = cacheflush_req_i | m_cf;
        hit_ok = req_i & cacheable_i & cache_hit_i & !flush_i & !pend;
        e.q    = cache_line_i[32*(off/4) +: 32];
        case (m_state)
            ARMED: begin
                e.ack   = hit_ok;
                e.be    = (hit_ok && we_i) ? be : 16'h0;
                e.nc    = req_i & !cacheable_i & !flush_i & !pend & (m_cnt < DEPTH);
                e.stall = req_i & (cacheable_i ? !cache_hit_i : !biu_stb_ack_i);
            end
            RECOVER: begin
                e.ack   = hit_ok;
                e.be    = (hit_ok && we_i) ? be : 16'h0;
                e.stall = !(req_i & cache_hit_i);
            end
            NONCACHEABLE: begin
                e.nc    = req_i & !cacheable_i & !flush_i & (m_cnt < DEPTH);
                e.ack   = biu_ack_i & !m_drop;
                e.err   = biu_err_i & !m_drop;
                e.q     = biu_q_i;
                e.stall = (req_i & !e.ack) | (m_cnt != 0);
            end
            EVICT, FILL: begin
                e.stall = 1'b1;
                e.err   = biu_err_i;
            end
            default: begin
                e.stall    = 1'b1;
                e.flushing = 1'b1;
            end
        endcase
        if (!rst_ni) begin
            e.stall = 0; e.ack = 0; e.err = 0; e.nc = 0; e.flushing = 0; e.be = 0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t    e;
        state_t  ns;
        biucmd_t ncmd;
        bit      pend;
        started <= 1'b1;
        if (!rst_ni) begin
            m_state <= ARMED; m_cmd <= NOP; m_cnt <= 0; m_drop <= 1'b0; m_cf <= 1'b0;
        end else begin
            e    = model_out();
            pend = cacheflush_req_i | m_cf;
            ns   = m_state;
            ncmd = NOP;
            case (m_state)
                ARMED: begin
                    if (pend) ns = FLUSH;
                    else if (flush_i) ns = ARMED;
                    else if (req_i && !cacheable_i) ns = NONCACHEABLE;
                    else if (req_i && !cache_hit_i) begin
                        ns   = victim_dirty_i ? EVICT : FILL;
                        ncmd = victim_dirty_i ? WRITEWAY : READWAY;
                    end
                end
                EVICT: begin
                    if (biu_err_i) ns = RECOVER;
                    else if (biucmd_ack_i) begin ns = FILL; ncmd = READWAY; end
                end
                FILL:         if (biu_err_i || biucmd_ack_i) ns = RECOVER;
                FLUSH:        if (dcflush_rdy_i) ns = RECOVER;
                RECOVER:      ns = ARMED;
                NONCACHEABLE: if (m_cnt == 0 && !e.nc) ns = ARMED;
                default:      ns = ARMED;
            endcase
            m_state <= ns;
            m_cmd   <= ncmd;
            if ((e.nc && biu_stb_ack_i) && !(biu_ack_i || biu_err_i) && m_cnt < DEPTH) m_cnt <= m_cnt + 1;
            else if (!(e.nc && biu_stb_ack_i) && (biu_ack_i || biu_err_i) && m_cnt > 0) m_cnt <= m_cnt - 1;
            if (m_state == NONCACHEABLE && m_cnt == 0 && !e.nc) m_drop <= 1'b0;
            else if (m_state == NONCACHEABLE && flush_i) m_drop <= 1'b1;
            if (m_state == ARMED && pend) m_cf <= 1'b0;
            else if (cacheflush_req_i && m_state != FLUSH) m_cf <= 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            e = model_out();
            chk("stall_o",    stall_o,    e.stall);
            chk("ack_o",      ack_o,      e.ack);
            chk("err_o",      err_o,      e.err);
            chk("nc_req_o",   nc_req_o,   e.nc);
            chk("flushing_o", flushing_o, e.flushing);
            chk("line_be_o",  line_be_o,  e.be);
            chk("biucmd_o",   biucmd_o,   m_cmd);
            chk("state",      dut.state_q, m_state);
            chk("cnt",        dut.nc_cnt, m_cnt);
            if (rst_ni && e.ack && (m_state == NONCACHEABLE || !we_i)) chk("q_o", q_o, e.q);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; cacheflush_req_i = 0; dcflush_rdy_i = 0; req_i = 0; we_i = 0;
        adr_i = '0; size_i = WORD; d_i = 32'hA5A5_5A5A; cacheable_i = 1; cache_hit_i = 0;
        victim_dirty_i = 0; biucmd_ack_i = 0; biu_stb_ack_i = 0; biu_ack_i = 0;
        biu_err_i = 0; biu_q_i = '0;
        cache_line_i = 128'h44444444_33333333_22222222_11111111;
    endtask

    initial begin
        rst_ni = 0;
        idle();
        req_i = 1; we_i = 1; cache_hit_i = 1;
        tick(); tick();
        #3;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_line_be", line_be_o, 16'h0);
        chk("rst_biucmd", biucmd_o, NOP);
        tick();
        rst_ni = 1; idle();
        tick();

        // Store hit, halfword at 0x8
        req_i = 1; we_i = 1; cache_hit_i = 1; adr_i = 34'h8; size_i = HWORD; d_i = 32'h1234;
        #3; chk("st_hit_be", line_be_o, 16'h0300); chk("st_hit_ack", ack_o, 1'b1);
        tick();
        // Load hit, word at 0x4
        we_i = 0; adr_i = 34'h4; size_i = WORD;
        #3; chk("ld_hit_q", q_o, 32'h22222222);
        tick();
        // Store byte at 0xF
        we_i = 1; adr_i = 34'hF; size_i = BYTE;
        #3; chk("st_byte_be", line_be_o, 16'h8000);
        tick(); idle(); tick();

        // Dirty miss
        req_i = 1; cache_hit_i = 0; victim_dirty_i = 1; adr_i = 34'h20;
        #3; chk("dm_stall0", stall_o, 1'b1);
        tick();
        #3; chk("dm_writeway", biucmd_o, WRITEWAY); chk("dm_stall1", stall_o, 1'b1);
        tick();
        biucmd_ack_i = 1;
        tick();
        biucmd_ack_i = 0;
        #3; chk("dm_readway", biucmd_o, READWAY); chk("dm_stall2", stall_o, 1'b1);
        tick();
        biucmd_ack_i = 1;
        tick();
        biucmd_ack_i = 0;
        #3; chk("dm_recover", dut.state_q, RECOVER); chk("dm_stall3", stall_o, 1'b1);
        tick();
        cache_hit_i = 1;
        #3; chk("dm_armed", dut.state_q, ARMED); chk("dm_hit_ack", ack_o, 1'b1);
        tick(); idle();

        // Clean miss ending in a bus error
        req_i = 1; cache_hit_i = 0;
        tick();
        biu_err_i = 1;
        #3; chk("fill_err", err_o, 1'b1);
        tick(); idle(); tick(); tick();

        // Three non-cacheable loads, none acknowledged
        req_i = 1; cacheable_i = 0; biu_stb_ack_i = 1;
        tick(); tick();
        #3; chk("nc3_req", nc_req_o, 1'b0); chk("nc3_cnt", dut.nc_cnt, 2'd2);
        tick();
        req_i = 0; biu_stb_ack_i = 0; flush_i = 1;
        tick();
        flush_i = 0; biu_ack_i = 1; biu_q_i = 32'hDEAD_BEEF;
        #3; chk("drop_ack1", ack_o, 1'b0);
        tick();
        #3; chk("drop_ack2", ack_o, 1'b0);
        tick();
        biu_ack_i = 0;
        tick();
        #3; chk("drop_armed", dut.state_q, ARMED);
        tick(); idle(); tick();

        // Non-cacheable load with simultaneous accept and completion
        req_i = 1; cacheable_i = 0; biu_stb_ack_i = 1;
        tick();
        biu_ack_i = 1; biu_q_i = 32'hCAFE_BABE;
        #3; chk("nc_ack", ack_o, 1'b1); chk("nc_q", q_o, 32'hCAFE_BABE);
        tick();
        #3; chk("nc_hold_cnt", dut.nc_cnt, 2'd1);
        req_i = 0; biu_stb_ack_i = 0; biu_q_i = 32'h1234_5678;
        tick();
        biu_ack_i = 0;
        tick(); tick(); idle(); tick();

        // Cache flush request arriving during a fill is latched
        req_i = 1; cache_hit_i = 0;
        tick();
        idle(); cacheflush_req_i = 1;
        tick();
        cacheflush_req_i = 0; biucmd_ack_i = 1;
        tick();
        biucmd_ack_i = 0;
        tick();
        tick();
        #3; chk("cf_flushing", flushing_o, 1'b1);
        tick();
        dcflush_rdy_i = 1;
        tick();
        dcflush_rdy_i = 0;
        tick(); tick();

        // Flush request beats a concurrent hit
        req_i = 1; cache_hit_i = 1; cacheflush_req_i = 1;
        #3; chk("cf_hit_noack", ack_o, 1'b0);
        tick();
        idle(); dcflush_rdy_i = 1;
        tick();
        idle();
        tick(); tick();

        // Reset in the middle of a fill
        req_i = 1; cache_hit_i = 0;
        tick();
        rst_ni = 0; idle();
        tick();
        rst_ni = 1;
        #3; chk("rst_fill_cmd", biucmd_o, NOP); chk("rst_fill_state", dut.state_q, ARMED);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
